// File: rtl/bayer_scan_ctrl_if.sv
// bayer_scan_ctrl_if: registered pixel stream from bayer_scan_ctrl to the demosaic datapath
//   oDATA    12  registered raw Bayer pixel
//   oX_Cont  11  column inside the crop window (0-based)
//   oY_Cont  11  row inside the crop window (0-based)
//   oDVAL     1  pixel inside window and capture active
//   oSOF      1  pulse with the first oDVAL of a frame
//   oEOF      1  pulse with the last oDVAL of a frame
//   master = producer (bayer_scan_ctrl), slave = consumer
interface bayer_scan_ctrl_if;
  logic [11:0] oDATA;
  logic [10:0] oX_Cont, oY_Cont;
  logic oDVAL, oSOF, oEOF;
  modport master (output oDATA, oX_Cont, oY_Cont, oDVAL, oSOF, oEOF);
  modport slave (input oDATA, oX_Cont, oY_Cont, oDVAL, oSOF, oEOF);
endinterface

// File: rtl/bayer_scan_ctrl.sv
// bayer_scan_ctrl: frame-aligned capture sequencer and even-aligned crop window for the demosaic stage
//   iCLK, iRST          pixel clock, asynchronous active-low reset
//   iSTART, iSTOP       arm request, stop request (stop wins, active frame completes first)
//   iFVAL, iLVAL, iDATA sensor frame/line valid and raw pixel
//   iX_START, iY_START  window origin (forced even)
//   iWIDTH, iHEIGHT     window size (forced even, minimum 2)
//   pix                 registered pixel stream (data, window counters, valid, SOF, EOF)
//   oSHORT              pulse when a frame ends before its window completed
//   oBUSY               capture armed or active
//   oFRAME_CNT          completed full-window frames
module bayer_scan_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic             iSTOP,
  input  logic             iFVAL,
  input  logic             iLVAL,
  input  logic [11:0]      iDATA,
  input  logic [10:0]      iX_START,
  input  logic [10:0]      iY_START,
  input  logic [10:0]      iWIDTH,
  input  logic [10:0]      iHEIGHT,
  bayer_scan_ctrl_if.master pix,
  output logic             oSHORT,
  output logic             oBUSY,
  output logic [CNT_W-1:0] oFRAME_CNT
);
  // ARMED is split so a frame already in flight at arm time is skipped:
  // ARM_WAIT until iFVAL is seen low, then ARM_RDY until it rises.
  typedef enum logic [1:0] {IDLE, ARM_WAIT, ARM_RDY, ACTIVE} state_t;
  state_t state, stateNext;
  logic stopPending, frameDone, lvalPrev;
  logic frameStart, frameEnd, valid, inWin, eofNow;
  logic [10:0] sx, sy, x0, y0, w, h;
  logic [10:0] inX0, inY0, inW, inH;
  logic [10:0] curSx, curSy, effX0, effY0, effW, effH, xc, yc;
  function automatic logic [10:0] satInc(input logic [10:0] v);
    return (&v) ? v : v + 11'd1;
  endfunction
  always_comb begin
    inX0 = iX_START & ~11'd1;
    inY0 = iY_START & ~11'd1;
    inW = (iWIDTH < 11'd2) ? 11'd2 : iWIDTH & ~11'd1;
    inH = (iHEIGHT < 11'd2) ? 11'd2 : iHEIGHT & ~11'd1;
    frameStart = state == ARM_RDY && iFVAL && !iSTOP;
    frameEnd = state == ACTIVE && !iFVAL;
    valid = iFVAL && iLVAL;
    // The FVAL-rise pixel is already part of the frame, so it sees cleared
    // counters and the freshly latched window.
    curSx = frameStart ? 11'd0 : sx;
    curSy = frameStart ? 11'd0 : sy;
    effX0 = frameStart ? inX0 : x0;
    effY0 = frameStart ? inY0 : y0;
    effW = frameStart ? inW : w;
    effH = frameStart ? inH : h;
    xc = curSx - effX0;
    yc = curSy - effY0;
    // Lower bound first, so the offset compare never sees a wrapped value.
    inWin = (frameStart || state == ACTIVE) && valid
            && curSx >= effX0 && xc < effW && curSy >= effY0 && yc < effH;
    eofNow = inWin && xc == effW - 11'd1 && yc == effH - 11'd1;
  end
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     stateNext = (iSTART && !iSTOP) ? ARM_WAIT : IDLE;
      ARM_WAIT: stateNext = iSTOP ? IDLE : iFVAL ? ARM_WAIT : ARM_RDY;
      ARM_RDY:  stateNext = iSTOP ? IDLE : iFVAL ? ACTIVE : ARM_RDY;
      ACTIVE:   stateNext = !frameEnd ? ACTIVE : (stopPending || iSTOP) ? IDLE : ARM_RDY;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= IDLE;
      stopPending <= 1'b0;
      frameDone <= 1'b0;
      lvalPrev <= 1'b0;
      sx <= '0;
      sy <= '0;
      x0 <= '0;
      y0 <= '0;
      w <= '0;
      h <= '0;
      oSHORT <= 1'b0;
      oBUSY <= 1'b0;
      oFRAME_CNT <= '0;
      pix.oDATA <= '0;
      pix.oX_Cont <= '0;
      pix.oY_Cont <= '0;
      pix.oDVAL <= 1'b0;
      pix.oSOF <= 1'b0;
      pix.oEOF <= 1'b0;
    end else begin
      state <= stateNext;
      stopPending <= state == ACTIVE && !frameEnd && (stopPending || iSTOP);
      frameDone <= frameEnd ? 1'b0 : frameDone || eofNow;
      lvalPrev <= iLVAL;
      sx <= !iLVAL ? 11'd0 : valid ? satInc(curSx) : curSx;
      sy <= (lvalPrev && !iLVAL && !frameStart) ? satInc(curSy) : curSy;
      if (frameStart) begin
        x0 <= inX0;
        y0 <= inY0;
        w <= inW;
        h <= inH;
      end
      oSHORT <= frameEnd && !frameDone;
      oBUSY <= stateNext != IDLE;
      if (frameEnd && frameDone) oFRAME_CNT <= oFRAME_CNT + CNT_W'(1);
      pix.oDATA <= iDATA;
      pix.oDVAL <= inWin;
      pix.oSOF <= inWin && xc == 11'd0 && yc == 11'd0;
      pix.oEOF <= eofNow;
      if (inWin) begin
        pix.oX_Cont <= xc;
        pix.oY_Cont <= yc;
      end
    end
  end
endmodule

// File: tb/tb_bayer_scan_ctrl.sv
// tb_bayer_scan_ctrl: directed self-checking bench for bayer_scan_ctrl on an 8x6 synthetic sensor
module tb_bayer_scan_ctrl;
  logic iCLK = 0, iRST = 0, iSTART = 0, iSTOP = 0, iFVAL = 0, iLVAL = 0;
  logic [11:0] iDATA = '0;
  logic [10:0] iX_START = '0, iY_START = '0, iWIDTH = '0, iHEIGHT = '0;
  logic oSHORT, oBUSY;
  logic [15:0] oFRAME_CNT;
  bayer_scan_ctrl_if pix ();
  bayer_scan_ctrl #(.CNT_W(16)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP),
    .iFVAL(iFVAL), .iLVAL(iLVAL), .iDATA(iDATA),
    .iX_START(iX_START), .iY_START(iY_START), .iWIDTH(iWIDTH), .iHEIGHT(iHEIGHT),
    .pix(pix), .oSHORT(oSHORT), .oBUSY(oBUSY), .oFRAME_CNT(oFRAME_CNT)
  );
  always #5 iCLK = ~iCLK;
  int nChk = 0, nFail = 0;
  int cyc = 0, dvalCnt, sofCnt, eofCnt, shortCnt, pixErr, shortCyc, fallCyc, snapCnt;
  logic [11:0] sofData;
  logic [10:0] sofX, sofY, eofX, eofY, expX0, expY0;
  logic preDval;
  logic [54:0] snapAll;
  always @(posedge iCLK) cyc <= cyc + 1;
  // Sensor pixel data encodes {row, column}, so every valid output can be
  // traced back to its sensor position through the expected window origin.
  always @(negedge iCLK) begin
    if (pix.oDVAL) dvalCnt++;
    if (pix.oDVAL && pix.oDATA !== {6'(pix.oY_Cont + expY0), 6'(pix.oX_Cont + expX0)}) pixErr++;
    if (pix.oSOF) begin sofCnt++; sofData = pix.oDATA; sofX = pix.oX_Cont; sofY = pix.oY_Cont; end
    if (pix.oEOF) begin eofCnt++; eofX = pix.oX_Cont; eofY = pix.oY_Cont; end
    if (oSHORT) begin shortCnt++; shortCyc = cyc; end
  end
  task automatic step(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask
  task automatic clr();
    dvalCnt = 0; sofCnt = 0; eofCnt = 0; shortCnt = 0; pixErr = 0; shortCyc = -1;
  endtask
  task automatic set_win(input int x, input int y, input int wd, input int ht, input int ex, input int ey);
    iX_START = 11'(x); iY_START = 11'(y); iWIDTH = 11'(wd); iHEIGHT = 11'(ht);
    expX0 = 11'(ex); expY0 = 11'(ey);
  endtask
  task automatic send_frame(input int lines, input int pixels, input int stopLine, input int startLine, input int rstLine);
    iFVAL = 0; iLVAL = 0; step(2);
    iFVAL = 1; step(1);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < pixels; x++) begin
        iLVAL = 1; iDATA = {6'(y), 6'(x)};
        iSTOP = (y == stopLine && x == 0);
        iSTART = (y == startLine && x == 0);
        if (y == rstLine && x == 3) begin
          preDval = pix.oDVAL;
          iRST = 0;
          #1;
          snapAll = {pix.oDVAL, pix.oSOF, pix.oEOF, oSHORT, oBUSY, pix.oDATA, pix.oX_Cont, pix.oY_Cont, oFRAME_CNT};
          snapCnt = dvalCnt;
          step(1);
          iRST = 1;
        end else step(1);
      end
      iLVAL = 0; iSTOP = 0; iSTART = 0; step(2);
    end
    iFVAL = 0; fallCyc = cyc + 1; step(3);
  endtask
  task automatic test_reset();
    step(2);
    nChk++; if (pix.oDVAL !== 1'b0 || pix.oSOF !== 1'b0 || pix.oEOF !== 1'b0) begin nFail++; $display("FAIL reset_flags got %b%b%b want 000", pix.oDVAL, pix.oSOF, pix.oEOF); end
    nChk++; if (oBUSY !== 1'b0 || oSHORT !== 1'b0) begin nFail++; $display("FAIL reset_busy_short got %b%b want 00", oBUSY, oSHORT); end
    nChk++; if (oFRAME_CNT !== 16'd0) begin nFail++; $display("FAIL reset_cnt got %0d want 0", oFRAME_CNT); end
    nChk++; if (pix.oX_Cont !== 11'd0 || pix.oY_Cont !== 11'd0 || pix.oDATA !== 12'd0) begin nFail++; $display("FAIL reset_xy got %0d,%0d data %0h want 0,0 data 0", pix.oX_Cont, pix.oY_Cont, pix.oDATA); end
    iRST = 1; step(1);
  endtask
  task automatic test_basic_window();
    set_win(2, 2, 4, 2, 2, 2); clr();
    iSTART = 1; step(1); iSTART = 0;
    nChk++; if (oBUSY !== 1'b1) begin nFail++; $display("FAIL basic_busy got %b want 1", oBUSY); end
    send_frame(6, 8, -1, -1, -1);
    nChk++; if (dvalCnt !== 8) begin nFail++; $display("FAIL basic_dval got %0d want 8", dvalCnt); end
    nChk++; if (sofCnt !== 1 || sofX !== 11'd0 || sofY !== 11'd0) begin nFail++; $display("FAIL basic_sof got cnt %0d at %0d,%0d want 1 at 0,0", sofCnt, sofX, sofY); end
    nChk++; if (sofData !== {6'd2, 6'd2}) begin nFail++; $display("FAIL basic_sof_data got %0h want %0h", sofData, {6'd2, 6'd2}); end
    nChk++; if (eofCnt !== 1 || eofX !== 11'd3 || eofY !== 11'd1) begin nFail++; $display("FAIL basic_eof got cnt %0d at %0d,%0d want 1 at 3,1", eofCnt, eofX, eofY); end
    nChk++; if (oFRAME_CNT !== 16'd1) begin nFail++; $display("FAIL basic_cnt got %0d want 1", oFRAME_CNT); end
    nChk++; if (shortCnt !== 0) begin nFail++; $display("FAIL basic_short got %0d want 0", shortCnt); end
    nChk++; if (pixErr !== 0) begin nFail++; $display("FAIL basic_pixels got %0d bad want 0", pixErr); end
  endtask
  task automatic test_stop();
    clr();
    send_frame(6, 8, 3, -1, -1);
    nChk++; if (dvalCnt !== 8 || eofCnt !== 1) begin nFail++; $display("FAIL stop_complete got dval %0d eof %0d want 8 1", dvalCnt, eofCnt); end
    nChk++; if (oFRAME_CNT !== 16'd2) begin nFail++; $display("FAIL stop_cnt got %0d want 2", oFRAME_CNT); end
    nChk++; if (oBUSY !== 1'b0) begin nFail++; $display("FAIL stop_busy got %b want 0", oBUSY); end
    clr();
    send_frame(6, 8, -1, -1, -1);
    nChk++; if (dvalCnt !== 0 || oBUSY !== 1'b0) begin nFail++; $display("FAIL stop_idle got dval %0d busy %b want 0 0", dvalCnt, oBUSY); end
  endtask
  task automatic test_mid_start();
    clr();
    send_frame(6, 8, -1, 1, -1);
    nChk++; if (dvalCnt !== 0) begin nFail++; $display("FAIL midstart_partial got %0d want 0", dvalCnt); end
    nChk++; if (oBUSY !== 1'b1) begin nFail++; $display("FAIL midstart_busy got %b want 1", oBUSY); end
    clr();
    send_frame(6, 8, -1, -1, -1);
    nChk++; if (dvalCnt !== 8 || sofCnt !== 1 || eofCnt !== 1) begin nFail++; $display("FAIL midstart_next got dval %0d sof %0d eof %0d want 8 1 1", dvalCnt, sofCnt, eofCnt); end
    nChk++; if (oFRAME_CNT !== 16'd3) begin nFail++; $display("FAIL midstart_cnt got %0d want 3", oFRAME_CNT); end
  endtask
  task automatic test_odd_window();
    set_win(3, 5, 5, 3, 2, 4); clr();
    send_frame(6, 8, -1, -1, -1);
    nChk++; if (dvalCnt !== 8) begin nFail++; $display("FAIL odd_dval got %0d want 8", dvalCnt); end
    nChk++; if (sofData !== {6'd4, 6'd2}) begin nFail++; $display("FAIL odd_sof_data got %0h want %0h", sofData, {6'd4, 6'd2}); end
    nChk++; if (eofCnt !== 1 || eofX !== 11'd3 || eofY !== 11'd1) begin nFail++; $display("FAIL odd_eof got cnt %0d at %0d,%0d want 1 at 3,1", eofCnt, eofX, eofY); end
    nChk++; if (pixErr !== 0 || oFRAME_CNT !== 16'd4) begin nFail++; $display("FAIL odd_pixels got bad %0d cnt %0d want 0 4", pixErr, oFRAME_CNT); end
  endtask
  task automatic test_short();
    set_win(2, 2, 4, 10, 2, 2); clr();
    send_frame(6, 8, -1, -1, -1);
    nChk++; if (dvalCnt !== 16 || eofCnt !== 0) begin nFail++; $display("FAIL short_out got dval %0d eof %0d want 16 0", dvalCnt, eofCnt); end
    nChk++; if (shortCnt !== 1) begin nFail++; $display("FAIL short_pulses got %0d want 1", shortCnt); end
    nChk++; if (shortCyc !== fallCyc) begin nFail++; $display("FAIL short_timing got cycle %0d want %0d", shortCyc, fallCyc); end
    nChk++; if (oFRAME_CNT !== 16'd4) begin nFail++; $display("FAIL short_cnt got %0d want 4", oFRAME_CNT); end
  endtask
  task automatic test_reset_mid();
    set_win(2, 2, 4, 2, 2, 2); clr();
    send_frame(6, 8, -1, -1, 2);
    nChk++; if (preDval !== 1'b1) begin nFail++; $display("FAIL rstmid_pre got %b want 1", preDval); end
    nChk++; if (snapAll !== 55'd0) begin nFail++; $display("FAIL rstmid_async got %0h want 0", snapAll); end
    nChk++; if (dvalCnt !== snapCnt) begin nFail++; $display("FAIL rstmid_rest got %0d want %0d", dvalCnt, snapCnt); end
    clr();
    send_frame(6, 8, -1, -1, -1);
    nChk++; if (dvalCnt !== 0 || oBUSY !== 1'b0 || oFRAME_CNT !== 16'd0) begin nFail++; $display("FAIL rstmid_later got dval %0d busy %b cnt %0d want 0 0 0", dvalCnt, oBUSY, oFRAME_CNT); end
  endtask
  task automatic test_start_stop();
    iSTART = 1; iSTOP = 1; step(1);
    iSTART = 0; iSTOP = 0; step(1);
    nChk++; if (oBUSY !== 1'b0) begin nFail++; $display("FAIL startstop_busy got %b want 0", oBUSY); end
  endtask
  initial begin
    test_reset();
    test_basic_window();
    test_stop();
    test_mid_start();
    test_odd_window();
    test_short();
    test_reset_mid();
    test_start_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule

// File: doc/bayer_scan_ctrl.md
# bayer_scan_ctrl

Frame sequencer in front of the Bayer demosaic stage. It arms and disarms capture on request and aligns to whole sensor frames using FVAL/LVAL. It crops a programmable even-aligned window and produces the X/Y counters, gated data-valid and frame-boundary pulses that the demosaic datapath and downstream frame logic consume. It sits between the sensor capture interface and the demosaic block.

## Interface
Parameters:
- CNT_W, 16, width of oFRAME_CNT

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  reset, asynchronous, active-low
- iSTART  in  1  arm request (level sampled each cycle)
- iSTOP  in  1  stop request; the frame in progress completes first
- iFVAL  in  1  sensor frame valid
- iLVAL  in  1  sensor line valid; a pixel is valid when iFVAL & iLVAL
- iDATA  in  12  raw Bayer pixel
- iX_START, iY_START  in  11  window origin in sensor pixels; bit0 ignored (forced even)
- iWIDTH, iHEIGHT  in  11  window size; bit0 ignored; values below 2 are treated as 2
- oDATA  out  12  registered pixel
- oX_Cont, oY_Cont  out  11  position inside the window (0-based)
- oDVAL  out  1  pixel inside window and capture active
- oSOF  out  1  one-cycle pulse with the first oDVAL of a frame
- oEOF  out  1  one-cycle pulse with the last oDVAL of a frame
- oSHORT  out  1  one-cycle pulse: frame ended before the window completed
- oBUSY  out  1  state is ARMED or ACTIVE
- oFRAME_CNT  out  CNT_W  completed full-window frames

## Operation
- States:
  - IDLE → ARMED on iSTART.
  - ARMED waits for iFVAL low for at least 1 cycle. A subsequent iFVAL rise → ACTIVE. This rejects a partial frame in flight.
  - ACTIVE → on iFVAL fall: IDLE if stop_pending, else ARMED.
- iSTOP in ARMED → IDLE immediately. iSTOP in ACTIVE sets stop_pending, which clears on leaving ACTIVE. iSTART in ARMED or ACTIVE is ignored.
- iSTART and iSTOP asserted in the same cycle: iSTOP wins.
- Window registers (origin/size, after even-forcing and clamping) are latched on the iFVAL rising edge that enters ACTIVE. Input changes mid-frame have no effect.
- Sensor counters:
  - sx counts valid pixels in the current line. It clears on the iLVAL falling edge and at frame start.
  - sy counts iLVAL falling edges within the frame. It clears at frame start.
  - Both saturate at 2047.
- In window: ACTIVE & iFVAL & iLVAL & sx∈[X0, X0+W−1] & sy∈[Y0, Y0+H−1]. Bounds are computed at 12 bits, with no wrap.
- oX_Cont = sx−X0 and oY_Cont = sy−Y0 when in window; otherwise both hold their last value. Even origins preserve Bayer phase.
- oEOF fires when in window with oX_Cont=W−1 and oY_Cont=H−1. It sets frame_done.
- On the iFVAL fall in ACTIVE:
  - frame_done=1: oFRAME_CNT increments (wrapping at 2^CNT_W).
  - frame_done=0: oSHORT pulses.
  - frame_done clears either way.

## Timing
- Every output is registered; latency iDATA→oDATA is 1 cycle. oDVAL, oX_Cont, oY_Cont, oSOF and oEOF are aligned to oDATA.
- State transitions take effect on the clock edge where the condition is sampled. The pixel on the iFVAL-rise cycle is already in ACTIVE and eligible for output.
- oSHORT and the oFRAME_CNT update appear 1 cycle after the cycle on which iFVAL is sampled low.
- Reset values: all outputs 0, state IDLE, stop_pending 0, frame_done 0, counters 0.
- Reset mid-frame aborts immediately. After release, a fresh iSTART and a full FVAL low→high sequence are required before any oDVAL.
- Single-pixel lines, W=2 and H=2 are legal. A window extending beyond the sensor frame yields oSHORT and no oEOF.

## Test plan
- Reset, iSTART, 8×6 sensor frame, window origin (2,2), size 4×2 → exactly 8 oDVAL; oSOF with (0,0); oEOF with (3,1); oFRAME_CNT=1; no oSHORT.
- iSTART asserted mid-frame (iFVAL high) → no oDVAL until the next FVAL rise; that next frame outputs fully.
- iSTOP during row 1 of the window → current frame completes with oEOF; oFRAME_CNT increments; state IDLE; the following frame produces no oDVAL; oBUSY=0.
- Window origin (3,5), size 5×3 → treated as (2,4), size 4×2; the first oDVAL coincides with sensor pixel (2,4).
- Window height 10 on a 6-line frame → no oEOF; oSHORT one pulse after FVAL fall; oFRAME_CNT unchanged.
- iRST low for 1 cycle during the window → all outputs 0 within that cycle (asynchronous); no oDVAL for the remainder of that frame or any later frame without a new iSTART.
